ltc5548_sys_onchip_burst_memory: RTL
====================================

Name: ltc5548_sys_onchip_burst_memory

Overview:
Parametrised successor to the system's single-port on-chip RAM.
- Avalon-MM slave with burst support, pipelined reads with `readdatavalid`, configurable read latency, and `waitrequest` flow control.
- Sits on the Nios/DMA interconnect as program/data or capture-buffer memory for the LTC5548 system.
- Keeps the existing `clken` / `reset_req` clock-gating semantics.

Parameters:
- `DATA_W`, 32: data word width; must be a multiple of 8.
- `ADDR_W`, 15: word address width.
- `DEPTH`, 32768: number of words; must satisfy `DEPTH <= 2**ADDR_W`.
- `READ_LATENCY`, 1: cycles from beat issue to `readdatavalid`; legal values 1..3.
- `BURST_W`, 4: `burstcount` width; maximum burst is `2**(BURST_W-1)` = 8 beats.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `reset_req`, in, 1: reset request; suppresses clock enable.
- `clken`, in, 1: clock enable.
- `chipselect`, in, 1: slave select.
- `address`, in, `ADDR_W`: word address, sampled on the first beat only.
- `byteenable`, in, `DATA_W/8`: write byte lanes.
- `write`, in, 1: write request.
- `writedata`, in, `DATA_W`: write data.
- `read`, in, 1: read request.
- `burstcount`, in, `BURST_W`: beats in the burst.
- `waitrequest`, out, 1: slave stall.
- `readdata`, out, `DATA_W`: read data.
- `readdatavalid`, out, 1: `readdata` qualifier.

Behaviour:
- Effective enable: `en = clken & ~reset_req`.
  - When `en = 0`: FSM, counters, RAM and read pipeline all hold; `waitrequest = 1`; `readdatavalid = 0`; no RAM write.
  - When `en` returns to 1: the pipeline resumes with no lost or duplicated beats.
- Reset (synchronous, highest priority, including mid-burst):
  - state = IDLE; beat counter = 0; all pipeline valid bits = 0.
  - Outputs: `waitrequest = 0` (while `en = 1`), `readdatavalid = 0`, `readdata = 0`.
  - RAM contents are not cleared.
- `burstcount = 0` is treated as 1.
- Addresses increment by one word per beat and wrap modulo `DEPTH`. Example: `DEPTH = 32768`, start 0x7FFE, 4 beats -> 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- FSM states: IDLE, WR_BURST, RD_BURST.
- IDLE, command accepted when `chipselect & (read | write) & en` and `waitrequest = 0`:
  - `write` (has priority if `read` is also high): write beat 0 immediately with `byteenable`. If burst > 1, go to WR_BURST with `remaining = burst - 1`.
  - `read`: latch the address, issue beat 0 this cycle, `remaining = burst - 1`. If `remaining > 0`, go to RD_BURST.
- WR_BURST:
  - `waitrequest = 0`; each cycle with `chipselect & write & en` writes the next sequential address and decrements `remaining`. Idle cycles (write low) are allowed and do not count.
  - `address` is ignored on these beats.
  - `read` is ignored.
  - Return to IDLE after the last beat.
- RD_BURST:
  - `waitrequest = 1`; issue one beat per enabled cycle with no master involvement. Return to IDLE the cycle after the last issue.
  - A new command may be accepted on the first IDLE cycle, even while earlier read data is still draining from the pipeline.
- Read pipeline:
  - A beat issued at cycle T produces `readdatavalid = 1` with data at T + `READ_LATENCY`, in order, with no bubbles between consecutive issued beats.
  - Read-during-write is impossible because the RAM is single-port and the FSM serialises accesses.
- Byte lanes: lane i = `writedata[8i+7:8i]`, written only when `byteenable[i] = 1`. `byteenable` applies only to writes; reads always return the full word.
- `readdata` holds its last valid value when `readdatavalid = 0`.

Decomposition:
- Package `ltc5548_sys_mem_pkg`:
  - State enum (IDLE, WR_BURST, RD_BURST).
  - `MAX_READ_LATENCY = 3`.
  - Helper function computing max burst from `BURST_W`.
- Sub-module `ltc5548_sys_ram_core`:
  - Single-port behavioural byte-enable RAM (`DATA_W`, `DEPTH`, `en`) with a 1-cycle registered read, so it infers a block RAM.
  - The top level adds `READ_LATENCY - 1` extra data/valid stages.

Test Plan:
- Single write then read: write 0xDEADBEEF to 0x0010 with byteenable 0xF; read 0x0010 with `READ_LATENCY = 1` -> `readdatavalid` high exactly one cycle later, data 0xDEADBEEF.
- Byte-lane masking: 0x11223344 is at 0x0020; write 0xAABBCCDD with byteenable 0b0101; read back -> 0x11BB33DD.
- Wrapped read burst: `DEPTH = 32768`, `READ_LATENCY = 2`, burst 4 from 0x7FFE (preloaded with 1, 2, 3, 4 at 0x7FFE, 0x7FFF, 0x0000, 0x0001) -> `waitrequest` high 3 cycles, 4 consecutive valid beats returning 1, 2, 3, 4, first beat 2 cycles after acceptance.
- Write burst with gaps: burst 3 at 0x0100, write deasserted for 2 cycles between beats 1 and 2 -> 0x0100..0x0102 hold the three data words; FSM in IDLE after beat 3.
- Stall: `clken` low for 3 cycles during an 8-beat read burst -> no `readdatavalid` while low; all 8 beats delivered in order with no duplicates. Repeat with `reset_req` high instead of `clken` low -> identical result.
- Reset mid-burst: assert `reset` on beat 3 of an 8-beat read -> next cycle `readdatavalid = 0`, state IDLE, `waitrequest = 0`; a following read of 0x0010 returns the previously written data.

Source files
------------

// File: rtl/ltc5548_sys_mem_pkg.sv
// Shared types and constants for the LTC5548 on-chip burst memory.
// Imported by the burst-memory top level and its RAM core.
package ltc5548_sys_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } mem_state_t;

    localparam int MAX_READ_LATENCY = 3;

    // Largest burst expressible on a burstcount bus of the given width.
    function automatic int max_burst(input int burst_w);
        return 1 << (burst_w - 1);
    endfunction

endpackage

// File: rtl/ltc5548_sys_onchip_burst_memory_if.sv
// Avalon-MM burst slave bus for the LTC5548 on-chip memory.
// The master drives the command side; the slave drives the stall and read-return side.
interface ltc5548_sys_onchip_burst_memory_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 15,
    parameter int BURST_W = 4
);
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic                  write;
    logic [DATA_W-1:0]     writedata;
    logic                  read;
    logic [BURST_W-1:0]    burstcount;
    logic                  waitrequest;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output chipselect, address, byteenable, write, writedata, read, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  chipselect, address, byteenable, write, writedata, read, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ltc5548_sys_ram_core.sv
// Single-port byte-enable RAM with a registered read port.
// Only the read register is resettable, which keeps the array mappable to a block RAM.
module ltc5548_sys_ram_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 32768
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                we,
    input  logic                rd,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = DATA_W / 8;

    logic [NB-1:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[addr][i] <= wdata[8*i +: 8];
        end
    end

    // rdata changes only on an issued read, so it holds between beats.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (en && rd)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/ltc5548_sys_onchip_burst_memory.sv
// Avalon-MM burst slave wrapping a single-port RAM, with configurable read latency
// and clken/reset_req clock-enable gating of every state element.
module ltc5548_sys_onchip_burst_memory
    import ltc5548_sys_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 15,
    parameter int DEPTH        = 32768,
    parameter int READ_LATENCY = 1,
    parameter int BURST_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_req,
    input  logic clken,
    ltc5548_sys_onchip_burst_memory_if.slave bus
);
    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..MAX_READ_LATENCY");
    end

    logic                    en;
    mem_state_t              state;
    logic [BURST_W-1:0]      remaining;
    logic [ADDR_W-1:0]       next_addr;
    logic [BURST_W-1:0]      burst_len;
    logic                    accept;
    logic                    ram_we;
    logic                    ram_rd;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       ram_rdata;
    logic [DATA_W-1:0]       rd_data;
    logic [READ_LATENCY:1]   vld_q;
    logic [READ_LATENCY:0]   vld_pipe;

    assign en = clken & ~reset_req;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    // The beat issued this cycle: from the bus in IDLE, from next_addr inside a burst.
    always_comb begin
        burst_len = (bus.burstcount == '0) ? BURST_W'(1) : bus.burstcount;
        accept    = (state == IDLE) & en & bus.chipselect & (bus.read | bus.write);
        ram_we    = 1'b0;
        ram_rd    = 1'b0;
        ram_addr  = next_addr;
        case (state)
            IDLE: begin
                ram_addr = bus.address;
                ram_we   = accept & bus.write;
                ram_rd   = accept & ~bus.write;
            end
            WR_BURST: ram_we = en & bus.chipselect & bus.write;
            RD_BURST: ram_rd = en;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            next_addr <= '0;
        end else if (en) begin
            if (ram_we | ram_rd)
                next_addr <= wrap_inc(ram_addr);
            case (state)
                IDLE: begin
                    if (accept && burst_len != BURST_W'(1)) begin
                        remaining <= burst_len - BURST_W'(1);
                        state     <= bus.write ? WR_BURST : RD_BURST;
                    end
                end
                WR_BURST, RD_BURST: begin
                    if (ram_we | ram_rd) begin
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ltc5548_sys_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .en    (en),
        .we    (ram_we),
        .rd    (ram_rd),
        .be    (bus.byteenable),
        .addr  (ram_addr),
        .wdata (bus.writedata),
        .rdata (ram_rdata)
    );

    // vld_pipe[k] marks a beat whose data sits k cycles after issue.
    assign vld_pipe = {vld_q, ram_rd};

    always_ff @(posedge clk) begin
        if (reset)
            vld_q <= '0;
        else if (en)
            vld_q <= vld_pipe[READ_LATENCY-1:0];
    end

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign rd_data = ram_rdata;
        end else begin : g_ext
            logic [READ_LATENCY-1:1][DATA_W-1:0] ext;
            always_ff @(posedge clk) begin
                if (reset) begin
                    ext <= '0;
                end else if (en) begin
                    if (vld_pipe[1]) ext[1] <= ram_rdata;
                    for (int k = 2; k < READ_LATENCY; k++)
                        if (vld_pipe[k]) ext[k] <= ext[k-1];
                end
            end
            assign rd_data = ext[READ_LATENCY-1];
        end
    endgenerate

    assign bus.waitrequest   = ~en | (state == RD_BURST);
    assign bus.readdatavalid = en & vld_pipe[READ_LATENCY];
    assign bus.readdata      = rd_data;

endmodule
